// File: rtl/ch_select_ctrl_if.sv
// Read port of the known-cluster-head table: the sequencer is master (strobe/address),
// the table is slave and returns ID/hops/Q one cycle after rd_en.
interface ch_select_ctrl_if #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] rd_id;
    logic [WORD_WIDTH-1:0] rd_hops;
    logic [WORD_WIDTH-1:0] rd_qvalue;

    modport master (output rd_en, rd_addr, input rd_id, rd_hops, rd_qvalue);
    modport slave  (input rd_en, rd_addr, output rd_id, rd_hops, rd_qvalue);
endinterface

// File: rtl/ch_select_ctrl.sv
// Cluster-head selection sequencer: scans the CH table and keeps the entry with the
// fewest hops, then highest Q. Optional macro CHSEL_LOWID_TIEBREAK_EN: lower ID wins full ties.
module ch_select_ctrl #(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_CH     = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  hb_reset,
    input  logic [ADDR_WIDTH:0]   num_entries,
    ch_select_ctrl_if.master      tbl,
    output logic                  busy,
    output logic                  done,
    output logic                  ch_valid,
    output logic [WORD_WIDTH-1:0] chosen_ch,
    output logic [WORD_WIDTH-1:0] hops_from_ch
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_WIDTH:0] MAX_N = (ADDR_WIDTH+1)'(MAX_CH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   n_lat;
    logic [ADDR_WIDTH:0]   n_clamp;
    logic                  rd_vld;
    logic                  last;
    logic [WORD_WIDTH-1:0] best_id, best_hops, best_q;
    logic                  found;
    logic                  cand_win;
    logic [WORD_WIDTH-1:0] nxt_id, nxt_hops, nxt_q;
    logic                  nxt_found;

    assign tbl.rd_en   = (state == SCAN);
    assign tbl.rd_addr = addr;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    assign n_clamp = (num_entries > MAX_N) ? MAX_N : num_entries;
    assign last    = ({1'b0, addr} == n_lat - 1'b1);

    // Compare the entry returned this cycle against the running best; the result is
    // forwarded so the final entry can be folded in on the DONE entry edge.
    always_comb begin
        cand_win = 1'b0;
        if (rd_vld && tbl.rd_id != '0) begin
            cand_win = !found
                    || (tbl.rd_hops < best_hops)
                    || (tbl.rd_hops == best_hops && tbl.rd_qvalue > best_q);
`ifdef CHSEL_LOWID_TIEBREAK_EN
            if (found && tbl.rd_hops == best_hops && tbl.rd_qvalue == best_q
                && tbl.rd_id < best_id)
                cand_win = 1'b1;
`endif
        end
        nxt_id    = cand_win ? tbl.rd_id     : best_id;
        nxt_hops  = cand_win ? tbl.rd_hops   : best_hops;
        nxt_q     = cand_win ? tbl.rd_qvalue : best_q;
        nxt_found = found | cand_win;
    end

    always_ff @(posedge clk) begin
        if (!nrst || hb_reset) begin
            state        <= IDLE;
            addr         <= '0;
            n_lat        <= '0;
            rd_vld       <= 1'b0;
            best_id      <= '0;
            best_hops    <= '1;
            best_q       <= '0;
            found        <= 1'b0;
            ch_valid     <= 1'b0;
            chosen_ch    <= '0;
            hops_from_ch <= '1;
        end else begin
            rd_vld    <= (state == SCAN);
            best_id   <= nxt_id;
            best_hops <= nxt_hops;
            best_q    <= nxt_q;
            found     <= nxt_found;
            case (state)
                IDLE: if (start) begin
                    n_lat     <= n_clamp;
                    addr      <= '0;
                    best_id   <= '0;
                    best_hops <= '1;
                    best_q    <= '0;
                    found     <= 1'b0;
                    if (n_clamp == '0) begin
                        state        <= DONE;
                        ch_valid     <= 1'b0;
                        chosen_ch    <= '0;
                        hops_from_ch <= '1;
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (last) begin
                        state <= DRAIN;
                        addr  <= '0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                DRAIN: begin
                    state        <= DONE;
                    ch_valid     <= nxt_found;
                    chosen_ch    <= nxt_id;
                    hops_from_ch <= nxt_hops;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ch_select_ctrl.sv
// Directed bench for ch_select_ctrl with a 1-cycle-latency table model.
module tb_ch_select_ctrl;
    logic        clk = 1'b0;
    logic        nrst, start, hb_reset;
    logic [4:0]  num_entries;
    logic        busy, done, ch_valid;
    logic [15:0] chosen_ch, hops_from_ch;

    ch_select_ctrl_if #(.WORD_WIDTH(16), .ADDR_WIDTH(4)) tbl ();

    ch_select_ctrl #(.WORD_WIDTH(16), .MAX_CH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .nrst(nrst), .start(start), .hb_reset(hb_reset),
        .num_entries(num_entries), .tbl(tbl), .busy(busy), .done(done),
        .ch_valid(ch_valid), .chosen_ch(chosen_ch), .hops_from_ch(hops_from_ch)
    );

    always #5 clk = ~clk;

    logic [15:0] mid [16];
    logic [15:0] mh  [16];
    logic [15:0] mq  [16];

    always @(posedge clk) begin
        if (tbl.rd_en) begin
            tbl.rd_id     <= mid[tbl.rd_addr];
            tbl.rd_hops   <= mh[tbl.rd_addr];
            tbl.rd_qvalue <= mq[tbl.rd_addr];
        end
    end

    int cyc = 0;
    int nreads = 0;
    int ndone = 0;
    int addrs[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (tbl.rd_en) begin
            nreads++;
            addrs.push_back(int'(tbl.rd_addr));
        end
        if (done) ndone++;
    end

    int npass = 0, nchk = 0;
    int t_start, t_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) begin
            mid[i] = '0; mh[i] = '0; mq[i] = '0;
        end
    endtask

    task automatic set_ent(input int i, input int id, input int h, input int q);
        mid[i] = 16'(id); mh[i] = 16'(h); mq[i] = 16'(q);
    endtask

    task automatic do_start(input int n);
        nreads = 0;
        addrs.delete();
        num_entries = 5'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        t_start = cyc;
    endtask

    // Leaves the bench in the done cycle; t_done is the cycle count there.
    task automatic wait_done(input string tag, input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            tick();
        end
        t_done = cyc;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    int nd;

    initial begin
        nrst = 1'b0; start = 1'b0; hb_reset = 1'b0; num_entries = '0;
        clear_tbl();
        tick(); tick();
        chk("rst_rd_en", 32'(tbl.rd_en), 0);
        chk("rst_rd_addr", 32'(tbl.rd_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(ch_valid), 0);
        chk("rst_ch", 32'(chosen_ch), 0);
        chk("rst_hops", 32'(hops_from_ch), 32'hFFFF);
        nrst = 1'b1;
        tick();

        // Hops decides; spec cycle T+k is observed k-1 counts after the accepting edge.
        set_ent(0, 5, 3, 10); set_ent(1, 7, 2, 4); set_ent(2, 9, 2, 8);
        do_start(3);
        chk("scan_busy_t1", 32'(busy), 1);
        wait_done("scan", 20);
        chk("scan_latency", 32'(t_done - t_start), 4);
        chk("scan_busy_done", 32'(busy), 1);
        chk("scan_ch", 32'(chosen_ch), 9);
        chk("scan_hops", 32'(hops_from_ch), 2);
        chk("scan_valid", 32'(ch_valid), 1);
        chk("scan_nreads", 32'(nreads), 3);
        chk("scan_addr0", 32'(addrs[0]), 0);
        chk("scan_addr1", 32'(addrs[1]), 1);
        chk("scan_addr2", 32'(addrs[2]), 2);
        tick();
        chk("scan_busy_after", 32'(busy), 0);
        chk("scan_done_pulse", 32'(done), 0);
        tick(); tick();
        chk("hold_ch", 32'(chosen_ch), 9);

        // Empty table
        do_start(0);
        wait_done("empty", 5);
        chk("empty_latency", 32'(t_done - t_start), 0);
        chk("empty_valid", 32'(ch_valid), 0);
        chk("empty_ch", 32'(chosen_ch), 0);
        chk("empty_hops", 32'(hops_from_ch), 32'hFFFF);
        chk("empty_nreads", 32'(nreads), 0);
        tick();

        // Skip empty slot
        clear_tbl();
        set_ent(0, 0, 1, 99); set_ent(1, 4, 6, 1);
        do_start(2);
        wait_done("skip", 20);
        chk("skip_ch", 32'(chosen_ch), 4);
        chk("skip_hops", 32'(hops_from_ch), 6);
        tick();

        // Clamp num_entries=20 to 16
        for (int i = 0; i < 16; i++) set_ent(i, i + 1, 10, i);
        set_ent(11, 12, 1, 3); set_ent(13, 14, 1, 7);
        do_start(20);
        wait_done("clamp", 40);
        chk("clamp_latency", 32'(t_done - t_start), 17);
        chk("clamp_nreads", 32'(nreads), 16);
        chk("clamp_ch", 32'(chosen_ch), 14);
        chk("clamp_hops", 32'(hops_from_ch), 1);
        tick();

        // Abort in the 2nd SCAN cycle
        clear_tbl();
        set_ent(0, 2, 5, 5); set_ent(1, 6, 4, 1); set_ent(2, 11, 4, 9); set_ent(3, 12, 4, 9);
        nd = ndone;
        do_start(4);
        tick();
        hb_reset = 1'b1;
        tick();
        hb_reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rd_en", 32'(tbl.rd_en), 0);
        chk("abort_valid", 32'(ch_valid), 0);
        chk("abort_ch", 32'(chosen_ch), 0);
        chk("abort_hops", 32'(hops_from_ch), 32'hFFFF);
        repeat (6) tick();
        chk("abort_no_done", 32'(ndone - nd), 0);
        do_start(4);
        wait_done("rescan", 20);
        chk("rescan_latency", 32'(t_done - t_start), 5);
        chk("rescan_ch", 32'(chosen_ch), 11);
        chk("rescan_hops", 32'(hops_from_ch), 4);
        tick();

        // Start re-pulsed while busy
        clear_tbl();
        set_ent(0, 5, 3, 10); set_ent(1, 7, 2, 4); set_ent(2, 9, 2, 8);
        nd = ndone;
        do_start(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("coll", 20);
        chk("coll_latency", 32'(t_done - t_start), 4);
        chk("coll_ch", 32'(chosen_ch), 9);
        tick(); tick(); tick();
        chk("coll_busy_after", 32'(busy), 0);
        chk("coll_ndone", 32'(ndone - nd), 1);

        // start and hb_reset together
        num_entries = 5'd3;
        start = 1'b1; hb_reset = 1'b1;
        tick();
        start = 1'b0; hb_reset = 1'b0;
        chk("both_busy", 32'(busy), 0);
        chk("both_rd_en", 32'(tbl.rd_en), 0);
        chk("both_ch", 32'(chosen_ch), 0);
        tick();
        chk("both_busy2", 32'(busy), 0);

        // Full tie
        clear_tbl();
        set_ent(0, 8, 2, 5); set_ent(1, 3, 2, 5);
        do_start(2);
        wait_done("tie", 20);
`ifdef CHSEL_LOWID_TIEBREAK_EN
        chk("tie_ch", 32'(chosen_ch), 3);
`else
        chk("tie_ch", 32'(chosen_ch), 8);
`endif
        chk("tie_hops", 32'(hops_from_ch), 2);
        tick();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
